ball_motion_ctrl: RTL and testbench
===================================

Name: ball_motion_ctrl

Overview:
Per-frame motion sequencer for the on-screen ball. It runs on the system clock and synchronises the VGA frame_clk. On each frame it performs keycode steering, edge bounce and the position commit as separate ordered states. Because of this ordering, the position update always uses the motion value decided in the same frame. Outputs feed the colour mapper exactly as the existing ball position bus does.

Parameters:
X_CENTER, 320, reset X position
Y_CENTER, 240, reset Y position
X_MIN, 0, leftmost legal coordinate
X_MAX, 639, rightmost legal coordinate
Y_MIN, 0, topmost legal coordinate
Y_MAX, 479, bottommost legal coordinate
STEP, 1, magnitude of per-frame motion on either axis
SIZE, 4, ball radius in pixels

Ports:
Clk  input  1  system clock; all state on rising edge
Reset_n  input  1  asynchronous, active-low reset
frame_clk  input  1  VGA vertical-sync frame strobe (asynchronous to Clk)
keycode  input  16  current USB keyboard keycode; 0 = no key
BallX  output  10  ball centre X (unsigned)
BallY  output  10  ball centre Y (unsigned)
BallS  output  10  ball radius, constant SIZE
busy  output  1  high whenever FSM is not in IDLE
frame_done  output  1  one-Clk pulse when a frame update has committed
overrun  output  1  sticky: a frame tick arrived while busy

Behaviour:
- Reset (Reset_n low, asynchronous): BallX=X_CENTER, BallY=Y_CENTER, X/Y motion=0, state=IDLE, busy=0, frame_done=0, overrun=0, synchroniser flops=0, latched key=0.
- frame_clk passes through a 2-flop synchroniser plus a rising-edge detector. tick is high for exactly one Clk per frame_clk rising edge.
- Motion registers: MX and MY, 10-bit two's complement. The negative step is ~STEP+1. All sums wrap mod 2^10.
- FSM (one Clk per state):
  - IDLE: when tick=1, go to CAPTURE; otherwise stay.
  - CAPTURE: kq <= keycode (sampled once per frame).
  - STEER: exact 16-bit compare on kq.
    - 26 (W): MY=-STEP, MX=0.
    - 22 (S): MY=+STEP, MX=0.
    - 7 (D): MX=+STEP, MY=0.
    - 4 (A): MX=-STEP, MY=0.
    - Any other value: MX and MY hold.
  - BOUNCE: each axis is evaluated independently on the current position and overrides STEER for that axis only.
    - Y: if BallY+SIZE >= Y_MAX, MY=-STEP. Else if BallY <= Y_MIN+SIZE, MY=+STEP.
    - X: the same rule using BallX, X_MIN and X_MAX.
    - Comparisons are unsigned. The low-edge test is written as pos <= MIN+SIZE so it cannot underflow.
  - MOVE: BallX <= BallX+MX, BallY <= BallY+MY, using the MX/MY values written in BOUNCE.
  - DONE: frame_done=1 for this cycle only, then go to IDLE.
- Latency: if tick is high in cycle T (state IDLE), the new position is visible at T+5 and frame_done is high at T+5. busy is high from T+1 through T+5.
- Simultaneous or extra events:
  - A tick in any state other than IDLE is dropped and sets overrun=1. overrun clears only on reset.
  - A keycode change outside CAPTURE has no effect until the next frame.
- Reset mid-operation (any state): the asynchronous return to all reset values. No partial position commit is allowed.
- BallS is tied to SIZE.
- Motion persists across frames with keycode=0. A ball at rest (MX=MY=0) stays still until a key is pressed.

Test Plan:
- Reset, then 3 frames with keycode=0 -> BallX=320, BallY=240 after every frame_done; busy=0 and overrun=0 while idle.
- keycode=7 for one frame, then keycode=0 for 2 frames -> BallX 321, 322, 323 and BallY=240; frame_done is exactly 5 Clk after tick each frame.
- keycode=7 held from 320 -> BallX climbs to 635. Next frame gives 634 (bounce overrides the key). It then oscillates 635/634 while D is held; BallY stays 240.
- keycode=26 held from 240 -> BallY falls to 4, the next frame gives 5, then it oscillates 4/5. Then keycode=22 for one frame gives +1, and keycode=0 afterwards continues +1 per frame.
- Second frame_clk edge arriving 3 Clk after the first tick -> only one position step occurs, overrun=1 and stays 1. A following normal tick still updates the position.
- Reset_n asserted low during BOUNCE with BallX=400 -> outputs become 320/240 immediately with busy=0 and frame_done=0. With Reset_n released and keycode=0, the next frame leaves the ball at 320/240.

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion sequencer: synchronises frame_clk, then steers, bounces
// and commits the ball position in ordered single-cycle states.
module ball_motion_ctrl #(
    parameter int unsigned X_CENTER = 320,
    parameter int unsigned Y_CENTER = 240,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 639,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned Y_MAX    = 479,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SIZE     = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    output logic [9:0]  BallX,
    output logic [9:0]  BallY,
    output logic [9:0]  BallS,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        STEER,
        BOUNCE,
        MOVE,
        DONE
    } state_t;

    localparam logic [9:0]  STEP_POS = 10'(STEP);
    localparam logic [9:0]  STEP_NEG = ~STEP_POS + 10'd1;
    localparam logic [10:0] SIZE_W   = 11'(SIZE);
    localparam logic [10:0] X_HI     = 11'(X_MAX);
    localparam logic [10:0] Y_HI     = 11'(Y_MAX);
    localparam logic [10:0] X_LO     = 11'(X_MIN + SIZE);
    localparam logic [10:0] Y_LO     = 11'(Y_MIN + SIZE);

    state_t      state, state_n;
    logic        fs1, fs2, fs3;
    logic        tick;
    logic [15:0] kq, kq_n;
    logic [9:0]  mx, my, mx_n, my_n;
    logic [9:0]  pos_x, pos_y, pos_x_n, pos_y_n;

    assign tick  = fs2 & ~fs3;
    assign BallX = pos_x;
    assign BallY = pos_y;
    assign BallS = 10'(SIZE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        kq_n       = kq;
        mx_n       = mx;
        my_n       = my;
        pos_x_n    = pos_x;
        pos_y_n    = pos_y;
        busy       = (state != IDLE);
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (tick) state_n = CAPTURE;
            end
            CAPTURE: begin
                kq_n    = keycode;
                state_n = STEER;
            end
            STEER: begin
                case (kq)
                    16'd26: begin my_n = STEP_NEG; mx_n = '0; end
                    16'd22: begin my_n = STEP_POS; mx_n = '0; end
                    16'd7:  begin mx_n = STEP_POS; my_n = '0; end
                    16'd4:  begin mx_n = STEP_NEG; my_n = '0; end
                    default: ;
                endcase
                state_n = BOUNCE;
            end
            BOUNCE: begin
                // Widened compares so pos+SIZE cannot wrap near the top of the range
                if ({1'b0, pos_y} + SIZE_W >= Y_HI)  my_n = STEP_NEG;
                else if ({1'b0, pos_y} <= Y_LO)      my_n = STEP_POS;
                if ({1'b0, pos_x} + SIZE_W >= X_HI)  mx_n = STEP_NEG;
                else if ({1'b0, pos_x} <= X_LO)      mx_n = STEP_POS;
                state_n = MOVE;
            end
            MOVE: begin
                pos_x_n = pos_x + mx;
                pos_y_n = pos_y + my;
                state_n = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs1     <= 1'b0;
            fs2     <= 1'b0;
            fs3     <= 1'b0;
            kq      <= '0;
            mx      <= '0;
            my      <= '0;
            pos_x   <= 10'(X_CENTER);
            pos_y   <= 10'(Y_CENTER);
            overrun <= 1'b0;
        end else begin
            fs1   <= frame_clk;
            fs2   <= fs1;
            fs3   <= fs2;
            kq    <= kq_n;
            mx    <= mx_n;
            my    <= my_n;
            pos_x <= pos_x_n;
            pos_y <= pos_y_n;
            if (tick && state != IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Randomised frame-level bench for ball_motion_ctrl against a per-frame
// arithmetic model of steering, bounce and position commit.
module tb_ball_motion_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic [15:0] keycode = '0;
    logic [9:0]  BallX, BallY, BallS;
    logic        busy, frame_done, overrun;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_x, m_y, m_mx, m_my;
    int m_ovr;

    ball_motion_ctrl #(
        .X_CENTER(320), .Y_CENTER(240), .X_MIN(0), .X_MAX(639),
        .Y_MIN(0), .Y_MAX(479), .STEP(1), .SIZE(4)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
        .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 320; m_y = 240; m_mx = 0; m_my = 0; m_ovr = 0;
    endtask

    task automatic model_frame(input int key);
        if (key == 26)      begin m_my = -1; m_mx = 0; end
        else if (key == 22) begin m_my = 1;  m_mx = 0; end
        else if (key == 7)  begin m_mx = 1;  m_my = 0; end
        else if (key == 4)  begin m_mx = -1; m_my = 0; end
        if (m_y + 4 >= 479) m_my = -1;
        else if (m_y <= 4)  m_my = 1;
        if (m_x + 4 >= 639) m_mx = -1;
        else if (m_x <= 4)  m_mx = 1;
        m_x = (m_x + m_mx + 1024) % 1024;
        m_y = (m_y + m_my + 1024) % 1024;
    endtask

    // One full frame; glitch raises a second frame_clk edge while busy.
    task automatic do_frame(input int key, input bit glitch);
        int n;
        int old_x, old_y;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        check("idle_busy", busy, 0);
        check("idle_overrun", overrun, m_ovr);
        keycode   = 16'(key);
        frame_clk = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge Clk);
            n++;
        end
        check("busy_rise", busy, 1);
        if (!busy) return;
        old_x = m_x;
        old_y = m_y;
        if (glitch) frame_clk = 1'b0;
        @(negedge Clk);
        keycode   = 16'($urandom);
        frame_clk = glitch;
        @(negedge Clk);
        @(negedge Clk);
        check("move_no_done", frame_done, 0);
        check("move_old_x", BallX, old_x);
        check("move_old_y", BallY, old_y);
        model_frame(key);
        if (glitch) m_ovr = 1;
        @(negedge Clk);
        check("done_pulse", frame_done, 1);
        check("done_busy", busy, 1);
        check("done_x", BallX, m_x);
        check("done_y", BallY, m_y);
        check("done_overrun", overrun, m_ovr);
        @(negedge Clk);
        check("after_busy", busy, 0);
        check("after_done", frame_done, 0);
    endtask

    initial begin
        int guard;
        int k;
        model_reset();
        #23;
        check("rst_x", BallX, 320);
        check("rst_y", BallY, 240);
        check("rst_s", BallS, 4);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_ovr", overrun, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        repeat (3) do_frame(0, 0);
        check("rest_x", BallX, 320);

        do_frame(7, 0);
        do_frame(0, 0);
        do_frame(0, 0);
        check("plan_x323", BallX, 323);
        check("plan_y240", BallY, 240);

        guard = 0;
        while (m_x < 635 && guard < 400) begin do_frame(7, 0); guard++; end
        check("climb_x635", BallX, 635);
        do_frame(7, 0);
        check("bounce_x634", BallX, 634);
        do_frame(7, 0);
        check("osc_x635", BallX, 635);
        check("climb_y", BallY, 240);

        guard = 0;
        while (m_y > 4 && guard < 400) begin do_frame(26, 0); guard++; end
        check("fall_y4", BallY, 4);
        do_frame(26, 0);
        check("bounce_y5", BallY, 5);
        do_frame(26, 0);
        check("osc_y4", BallY, 4);
        do_frame(22, 0);
        check("s_y5", BallY, 5);
        do_frame(0, 0);
        do_frame(0, 0);
        check("persist_y7", BallY, 7);

        do_frame(0, 1);
        check("ovr_set", overrun, 1);
        do_frame(0, 0);
        check("ovr_sticky", overrun, 1);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0: k = 0;
                1: k = 4;
                2: k = 7;
                3: k = 22;
                4: k = 26;
                default: k = int'($urandom_range(0, 65535));
            endcase
            repeat ($urandom_range(0, 4)) @(negedge Clk);
            do_frame(k, ($urandom_range(0, 15) == 0));
        end

        @(negedge Clk);
        Reset_n = 1'b0;
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        guard = 0;
        while (m_x < 400 && guard < 200) begin do_frame(7, 0); guard++; end
        check("pre_rst_x400", BallX, 400);

        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        keycode   = 16'd7;
        frame_clk = 1'b1;
        guard = 0;
        while (!busy && guard < 10) begin @(negedge Clk); guard++; end
        check("mid_busy", busy, 1);
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_x", BallX, 320);
        check("mid_rst_y", BallY, 240);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", frame_done, 0);
        check("mid_rst_ovr", overrun, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        do_frame(0, 0);
        check("post_rst_x", BallX, 320);
        check("post_rst_y", BallY, 240);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
